uart_comm_slv: RTL and testbench
================================

# uart_comm_slv

Device-side end of the host command link. It deserializes two UART bytes from the host into one 16-bit command and raises `cmd_rdy`. It also serializes one 8-bit response byte back to the host. It sits inside the logic-analyzer digital core between the `RX`/`TX` pins and the command-processing FSM, and is the counterpart of the host-side command master.

## Interface
- `BAUD_DIV`, default 108: clocks per bit at 100 MHz (≈921600 baud). Legal range is 16..4095 (12-bit counter).
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `RX` in 1: serial input from the host. Idle is high. Asynchronous to `clk`.
- `TX` out 1: serial output to the host. Idle is high.
- `cmd` out 16: last complete command, `{first byte, second byte}`.
- `cmd_rdy` out 1: level. Set when a full command is assembled.
- `clr_cmd_rdy` in 1: one-cycle pulse that clears `cmd_rdy`.
- `resp` in 8: response byte. Sampled only on the cycle `send_resp` is high.
- `send_resp` in 1: one-cycle pulse that starts transmitting `resp`.
- `resp_sent` out 1: level. Set when the stop bit of the response has completed.

## Operation
- **RX front end**
  - `RX` passes through two synchronizing flops, plus one flop for edge detection.
  - A start is the synchronized high→low transition while the receiver is idle.
- **RX bit FSM**
  - States: IDLE, START, DATA, STOP.
  - START loads the baud counter with `BAUD_DIV/2` (integer division). On expiry it re-samples: 0 → DATA; 1 → glitch, return to IDLE with no byte.
  - DATA samples 8 bits LSB first, one per `BAUD_DIV` clocks, shifting right into an 8-bit register.
  - STOP samples after `BAUD_DIV` clocks. 1 → byte valid (internal one-cycle `rx_rdy`). 0 → framing error, byte discarded, return to IDLE.
- **Command FSM**
  - States: WAIT_HI, WAIT_LO.
  - In WAIT_HI, `rx_rdy` stores the byte into `hi_byte`, clears `cmd_rdy`, and moves to WAIT_LO.
  - In WAIT_LO, `rx_rdy` loads `cmd <= {hi_byte, byte}`, sets `cmd_rdy`, and returns to WAIT_HI.
  - A framing error in WAIT_LO does not reset the pairing; the next valid byte completes the command.
- **`cmd_rdy` and `cmd` rules**
  - `cmd` holds its value until the next complete command.
  - `cmd_rdy` clears on `clr_cmd_rdy` or on receipt of the first byte of the next command.
  - If a set and `clr_cmd_rdy` occur in the same cycle, the set wins.
- **TX FSM**
  - States: IDLE, XMIT.
  - `send_resp` in IDLE loads the 10-bit frame `{1, resp, 0}`, clears `resp_sent`, and enters XMIT.
  - XMIT shifts LSB first, one bit per `BAUD_DIV` clocks, and returns to IDLE after 10 bits, setting `resp_sent`.
  - `send_resp` during XMIT is ignored: the frame in progress is not disturbed and `resp` is not re-sampled.
- **Independence:** RX and TX are fully independent. Full duplex is legal.

## Timing
- **Reset values:** `TX`=1, `cmd`=16'h0000, `cmd_rdy`=0, `resp_sent`=0. Both FSMs go to their idle states and the sync flops preset to 1, so no false start is seen coming out of reset.
- **RX latency**
  - Let E be the edge at which the falling edge of `RX` is detected at the sync output.
  - Start bit sampled at E + `BAUD_DIV/2`.
  - Data bit k (k = 0..7) sampled at E + `BAUD_DIV/2` + (k+1)·`BAUD_DIV`.
  - Stop bit sampled at E + `BAUD_DIV/2` + 9·`BAUD_DIV`.
  - `cmd_rdy` goes high on the clock after the stop sample of the second byte.
- **RX back-to-back:** after the stop sample the RX FSM is in IDLE, so a start edge arriving half a bit into the stop period is accepted.
- **TX latency**
  - The start bit drives `TX` low on the clock after `send_resp`.
  - Each bit lasts exactly `BAUD_DIV` clocks.
  - `resp_sent` rises on the clock the stop bit period ends, 10·`BAUD_DIV` + 1 clocks after `send_resp`.
  - A new `send_resp` is accepted on that same cycle.
- **Reset mid-frame:** asynchronous `rst_n` low at any point returns everything to reset values immediately.
  - A partial command is lost.
  - `TX` returns high within the reset assertion.

## Test plan
- **Basic command:** with `BAUD_DIV`=108, the host master sends 16'h0812.
  - `cmd`=16'h0812 and `cmd_rdy`=1, exactly 1 clk after the second stop-bit sample.
  - `cmd_rdy` stays 1 until `clr_cmd_rdy`.
- **Response:** pulse `send_resp` with `resp`=8'hA5.
  - `TX` carries 0,1,0,1,0,0,1,0,1,1, each bit 108 clks.
  - `resp_sent` rises at 1081 clks; the host master reports `resp`=8'hA5.
- **Back-to-back commands:** send 16'h0812, then immediately 16'h4C0F, with no `clr_cmd_rdy`.
  - `cmd_rdy` drops when byte 8'h4C is received.
  - `cmd_rdy` rises again with `cmd`=16'h4C0F.
- **Framing error and glitch:** send byte 8'h12 with stop bit forced 0, then a valid 8'h34, then 8'h56.
  - `cmd`=16'h3456, and `cmd_rdy` is set once.
  - A separate 20-clk low glitch on `RX` produces no byte.
- **Collisions**
  - `send_resp` pulsed mid-frame with a different `resp`: the frame in progress is unchanged.
  - `clr_cmd_rdy` coincident with the set cycle: `cmd_rdy`=1.
- **Reset mid-operation:** assert `rst_n` during the DATA state of the first byte.
  - All outputs return to reset values.
  - A subsequent 16'hFFFF command is received correctly.

Source files
------------

// File: rtl/uart_comm_slv.sv
// Device-side UART command link: assembles two received bytes into a 16-bit
// command and serializes one response byte back to the host.
module uart_comm_slv #(
  parameter int BAUD_DIV = 108
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam logic [11:0] HALF_LD = 12'(BAUD_DIV / 2 - 1);
  localparam logic [11:0] FULL_LD = 12'(BAUD_DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {CMD_WAIT_HI, CMD_WAIT_LO} cmd_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

  // ---------------- RX front end ----------------
  logic rx_meta, rx_sync, rx_prev, rx_fall;

  // Presetting to the idle level keeps reset release from looking like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value; blocking here would collapse the synchronizer chain.
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // ---------------- RX bit FSM ----------------
  rx_state_t   rx_state, rx_nxt;
  logic [11:0] rx_cnt;
  logic [2:0]  rx_bit_cnt;
  logic [7:0]  rx_byte;
  logic        rx_rdy;
  logic        rx_cnt_zero, rx_ld_half, rx_ld_full, rx_shift_en, rx_byte_ok;

  assign rx_cnt_zero = (rx_cnt == 12'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    rx_nxt      = rx_state;
    rx_ld_half  = 1'b0;
    rx_ld_full  = 1'b0;
    rx_shift_en = 1'b0;
    rx_byte_ok  = 1'b0;
    case (rx_state)
      RX_IDLE:
        if (rx_fall) begin
          rx_nxt     = RX_START;
          rx_ld_half = 1'b1;
        end
      RX_START:
        if (rx_cnt_zero) begin
          if (!rx_sync) begin
            rx_nxt     = RX_DATA;
            rx_ld_full = 1'b1;
          end else begin
            rx_nxt = RX_IDLE;
          end
        end
      RX_DATA:
        if (rx_cnt_zero) begin
          rx_shift_en = 1'b1;
          rx_ld_full  = 1'b1;
          if (rx_bit_cnt == 3'd7) rx_nxt = RX_STOP;
        end
      RX_STOP:
        if (rx_cnt_zero) begin
          rx_nxt     = RX_IDLE;
          rx_byte_ok = rx_sync;
        end
      default: rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt     <= 12'd0;
      rx_bit_cnt <= 3'd0;
      rx_byte    <= 8'h00;
      rx_rdy     <= 1'b0;
    end else begin
      if (rx_ld_half)        rx_cnt <= HALF_LD;
      else if (rx_ld_full)   rx_cnt <= FULL_LD;
      else if (!rx_cnt_zero) rx_cnt <= rx_cnt - 12'd1;

      if (rx_ld_half)       rx_bit_cnt <= 3'd0;
      else if (rx_shift_en) rx_bit_cnt <= rx_bit_cnt + 3'd1;

      if (rx_shift_en) rx_byte <= {rx_sync, rx_byte[7:1]};
      rx_rdy <= rx_byte_ok;
    end
  end

  // ---------------- Command FSM ----------------
  cmd_state_t cmd_state, cmd_nxt;
  logic [7:0] hi_byte;
  logic       hi_ld, cmd_ld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_state <= CMD_WAIT_HI;
    else        cmd_state <= cmd_nxt;
  end

  always_comb begin
    cmd_nxt = cmd_state;
    hi_ld   = 1'b0;
    cmd_ld  = 1'b0;
    case (cmd_state)
      CMD_WAIT_HI:
        if (rx_rdy) begin
          hi_ld   = 1'b1;
          cmd_nxt = CMD_WAIT_LO;
        end
      CMD_WAIT_LO:
        if (rx_rdy) begin
          cmd_ld  = 1'b1;
          cmd_nxt = CMD_WAIT_HI;
        end
      default: cmd_nxt = CMD_WAIT_HI;
    endcase
  end

  // A completed command takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_byte <= 8'h00;
      cmd     <= 16'h0000;
      cmd_rdy <= 1'b0;
    end else begin
      if (hi_ld)  hi_byte <= rx_byte;
      if (cmd_ld) cmd     <= {hi_byte, rx_byte};
      if (cmd_ld)                    cmd_rdy <= 1'b1;
      else if (hi_ld || clr_cmd_rdy) cmd_rdy <= 1'b0;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t   tx_state, tx_nxt;
  logic [9:0]  tx_frame;
  logic [11:0] tx_cnt;
  logic [3:0]  tx_bit_cnt;
  logic        tx_cnt_zero, tx_load, tx_shift_en, tx_done;

  assign tx_cnt_zero = (tx_cnt == 12'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_nxt;
  end

  always_comb begin
    tx_nxt      = tx_state;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    tx_done     = 1'b0;
    case (tx_state)
      TX_IDLE:
        if (send_resp) begin
          tx_load = 1'b1;
          tx_nxt  = TX_XMIT;
        end
      TX_XMIT:
        if (tx_cnt_zero) begin
          tx_shift_en = 1'b1;
          if (tx_bit_cnt == 4'd9) begin
            tx_done = 1'b1;
            tx_nxt  = TX_IDLE;
          end
        end
      default: tx_nxt = TX_IDLE;
    endcase
  end

  // The frame shifts in ones, so it is all ones (line idle) once the stop bit is out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_frame   <= 10'h3FF;
      tx_cnt     <= 12'd0;
      tx_bit_cnt <= 4'd0;
      resp_sent  <= 1'b0;
    end else begin
      if (tx_load)          tx_frame <= {1'b1, resp, 1'b0};
      else if (tx_shift_en) tx_frame <= {1'b1, tx_frame[9:1]};

      if (tx_load || tx_shift_en) tx_cnt <= FULL_LD;
      else if (!tx_cnt_zero)      tx_cnt <= tx_cnt - 12'd1;

      if (tx_load)          tx_bit_cnt <= 4'd0;
      else if (tx_shift_en) tx_bit_cnt <= tx_bit_cnt + 4'd1;

      if (tx_load)      resp_sent <= 1'b0;
      else if (tx_done) resp_sent <= 1'b1;
    end
  end

  assign TX = tx_frame[0];

endmodule

// File: tb/tb_uart_comm_slv.sv
// Scoreboard bench for uart_comm_slv: stimulus pushes expected commands and
// response bytes; negedge monitors pop and compare as the DUT presents them.
module tb_uart_comm_slv;

  localparam int N    = 108;
  localparam int HALF = N / 2;
  // Start drive -> 2 sync flops -> START entry (3) + half bit + 9 bits, then one clock to cmd_rdy.
  localparam int RDY_LAT = 3 + HALF + 9 * N + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  uart_comm_slv #(.BAUD_DIV(N)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_cmd[$];
  logic [7:0]  exp_resp[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Command monitor: every rising cmd_rdy must match the oldest expected command.
  int   rises = 0;
  int   last_rise_cyc = 0;
  logic rdy_prev = 1'b0;
  logic [15:0] ce;
  always @(negedge clk) begin
    if (rst_n && cmd_rdy && !rdy_prev) begin
      rises++;
      last_rise_cyc = cyc;
      if (exp_cmd.size() == 0) check("cmd_spurious", 32'(exp_cmd.size()), 1);
      else begin
        ce = exp_cmd.pop_front();
        check("cmd_value", 32'(cmd), 32'(ce));
      end
    end
    rdy_prev = cmd_rdy;
  end

  // Host-side receiver: samples TX mid-bit and compares the whole frame.
  bit         tx_busy = 1'b0;
  int         tx_mcnt = 0;
  int         tx_mbit = 0;
  logic [9:0] tx_frm;
  logic [7:0] te;
  always @(negedge clk) begin
    if (!rst_n) tx_busy = 1'b0;
    else if (!tx_busy) begin
      if (TX === 1'b0) begin
        tx_busy = 1'b1;
        tx_mcnt = 0;
        tx_mbit = 0;
      end
    end else begin
      tx_mcnt++;
      if (tx_mcnt == HALF + tx_mbit * N) begin
        tx_frm[tx_mbit] = TX;
        tx_mbit++;
        if (tx_mbit == 10) begin
          tx_busy = 1'b0;
          if (exp_resp.size() == 0) check("tx_spurious_frame", 32'(exp_resp.size()), 1);
          else begin
            te = exp_resp.pop_front();
            check("tx_frame", 32'(tx_frm), 32'({1'b1, te, 1'b0}));
          end
        end
      end
    end
  end

  task automatic uart_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (N) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_resp(input logic [7:0] r);
    resp = r;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int c0, ts, r0;
  logic [9:0] a5_frame;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(TX), 1);
    check("rst_cmd", 32'(cmd), 0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 0);
    check("rst_resp_sent", 32'(resp_sent), 0);
    rst_n = 1'b1;
    idle(20);

    // Basic command with exact latency and hold-until-clear.
    exp_cmd.push_back(16'h0812);
    uart_send(8'h08, 1'b1);
    c0 = cyc;
    uart_send(8'h12, 1'b1);
    check("cmd_rdy_latency", 32'(last_rise_cyc), 32'(c0 + RDY_LAT));
    idle(300);
    check("cmd_rdy_held", 32'(cmd_rdy), 1);
    pulse_clr();
    check("cmd_rdy_cleared", 32'(cmd_rdy), 0);

    // Back-to-back commands, no clear in between.
    exp_cmd.push_back(16'h0812);
    exp_cmd.push_back(16'h4C0F);
    uart_send(8'h08, 1'b1);
    uart_send(8'h12, 1'b1);
    check("b2b_rdy_first", 32'(cmd_rdy), 1);
    uart_send(8'h4C, 1'b1);
    check("b2b_rdy_drop_on_hi", 32'(cmd_rdy), 0);
    check("b2b_cmd_held", 32'(cmd), 32'h0812);
    uart_send(8'h0F, 1'b1);
    check("b2b_rdy_second", 32'(cmd_rdy), 1);

    // Framing error in WAIT_HI, then in WAIT_LO.
    r0 = rises;
    exp_cmd.push_back(16'h3456);
    uart_send(8'h12, 1'b0);
    idle(N);
    uart_send(8'h34, 1'b1);
    uart_send(8'h56, 1'b1);
    check("framing_single_set", 32'(rises - r0), 1);
    exp_cmd.push_back(16'h78BC);
    uart_send(8'h78, 1'b1);
    uart_send(8'h9A, 1'b0);
    idle(N);
    uart_send(8'hBC, 1'b1);

    // 20-clock glitch between the two bytes of a command.
    r0 = rises;
    exp_cmd.push_back(16'hA1B2);
    uart_send(8'hA1, 1'b1);
    RX = 1'b0;
    repeat (20) @(negedge clk);
    idle(2 * N);
    check("glitch_no_set", 32'(rises - r0), 0);
    uart_send(8'hB2, 1'b1);
    check("glitch_pairing_kept", 32'(rises - r0), 1);

    // Clear coincident with the set cycle.
    exp_cmd.push_back(16'hC3D4);
    uart_send(8'hC3, 1'b1);
    c0 = cyc;
    fork
      uart_send(8'hD4, 1'b1);
      begin
        while (cyc != c0 + RDY_LAT - 1) @(negedge clk);
        pulse_clr();
        check("set_beats_clr", 32'(cmd_rdy), 1);
      end
    join

    // Response A5 bit-by-bit, concurrently with an incoming command.
    exp_resp.push_back(8'hA5);
    exp_cmd.push_back(16'h2B7E);
    a5_frame = {1'b1, 8'hA5, 1'b0};
    fork
      begin
        ts = cyc;
        pulse_resp(8'hA5);
        resp = 8'h00;
        for (int b = 0; b < 10; b++) begin
          for (int j = 0; j < N; j++) begin
            if (j == 0 || j == N - 1) check($sformatf("tx_bit%0d_%0d", b, j), 32'(TX), 32'(a5_frame[b]));
            if (b == 9 && j == N - 1) check("resp_sent_not_early", 32'(resp_sent), 0);
            @(negedge clk);
          end
        end
        check("resp_sent_at_1081", 32'(resp_sent), 1);
        check("resp_sent_cycle", 32'(cyc - ts), 1081);
      end
      begin
        uart_send(8'h2B, 1'b1);
        uart_send(8'h7E, 1'b1);
      end
    join

    // send_resp during XMIT is ignored; a new send on the resp_sent cycle is accepted.
    exp_resp.push_back(8'h5A);
    ts = cyc;
    pulse_resp(8'h5A);
    check("resp_sent_cleared", 32'(resp_sent), 0);
    repeat (300) @(negedge clk);
    pulse_resp(8'h3C);
    while (!resp_sent && cyc < ts + 3000) @(negedge clk);
    check("collision_resp_sent_cycle", 32'(cyc - ts), 1081);
    exp_resp.push_back(8'h96);
    pulse_resp(8'h96);
    check("accept_on_done_cycle", 32'(resp_sent), 0);
    check("accept_start_bit", 32'(TX), 0);
    ts = cyc;
    while (!resp_sent && cyc < ts + 3000) @(negedge clk);
    check("second_resp_sent", 32'(resp_sent), 1);
    idle(2 * N);

    // Reset during DATA of the first byte, with a response frame in flight.
    pulse_resp(8'h00);
    RX = 1'b0;
    repeat (N) @(negedge clk);
    RX = 1'b1;
    repeat (N) @(negedge clk);
    RX = 1'b0;
    repeat (HALF) @(negedge clk);
    check("pre_reset_tx_low", 32'(TX), 0);
    check("pre_reset_cmd_rdy", 32'(cmd_rdy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(TX), 1);
    check("midrst_cmd", 32'(cmd), 0);
    check("midrst_cmd_rdy", 32'(cmd_rdy), 0);
    check("midrst_resp_sent", 32'(resp_sent), 0);
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * N);
    exp_cmd.push_back(16'hFFFF);
    uart_send(8'hFF, 1'b1);
    uart_send(8'hFF, 1'b1);
    idle(N);
    check("post_reset_cmd", 32'(cmd), 32'hFFFF);
    check("cmd_queue_drained", 32'(exp_cmd.size()), 0);
    check("resp_queue_drained", 32'(exp_resp.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
